// File: rtl/iobus_btn_pkg.sv
// Shared constants for the IOBUS button controller: button count,
// register offsets and the read-only ID word.
package iobus_btn_pkg;

    localparam int unsigned NUM_BTNS = 5;

    localparam logic [3:0] OFF_LEVEL  = 4'h0;
    localparam logic [3:0] OFF_EVENTS = 4'h4;
    localparam logic [3:0] OFF_IRQ_EN = 4'h8;
    localparam logic [3:0] OFF_ID     = 4'hC;

    localparam logic [31:0] ID_VALUE = 32'h0B7C_0001;

    // Word index within the window, i.e. io_addr[3:2].
    typedef enum logic [1:0] {
        REG_LEVEL  = OFF_LEVEL[3:2],
        REG_EVENTS = OFF_EVENTS[3:2],
        REG_IRQ_EN = OFF_IRQ_EN[3:2],
        REG_ID     = OFF_ID[3:2]
    } reg_word_e;

endpackage

// File: rtl/iobus_btn_ctrl_debounce.sv
// One button: 2-flop synchronizer, stability counter, debounced level
// and a one-cycle pulse registered alongside each 0->1 level change.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic stable,
    output logic rise
);

    localparam int unsigned CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            rise   <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            rise  <= 1'b0;
            // Any return to the stable value restarts the count, so short glitches never land.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync2;
                rise   <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/iobus_btn_ctrl.sv
// IOBUS-mapped button controller: debounced LEVEL, sticky press EVENTS,
// IRQ_EN mask and ID register in a 16-byte window, level interrupt out.
module iobus_btn_ctrl
    import iobus_btn_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0040,
    parameter int unsigned DB_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BTNS-1:0] btn_raw,
    input  logic [31:0]         io_addr,
    input  logic                io_rd,
    input  logic                io_wr,
    input  logic [31:0]         io_wdata,
    output logic [31:0]         io_rdata,
    output logic                io_sel,
    output logic                irq
);

    logic [NUM_BTNS-1:0] level;
    logic [NUM_BTNS-1:0] rise;
    logic [NUM_BTNS-1:0] events;
    logic [NUM_BTNS-1:0] irq_en;
    logic [NUM_BTNS-1:0] ev_clr;
    logic                aligned;
    logic                acc_ok;
    reg_word_e           word;

    logic [31:NUM_BTNS]  unused_wdata;
    assign unused_wdata = io_wdata[31:NUM_BTNS];

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn    (btn_raw[i]),
            .stable (level[i]),
            .rise   (rise[i])
        );
    end

    assign io_sel  = (io_addr[31:4] == BASE_ADDR[31:4]);
    assign aligned = (io_addr[1:0] == 2'b00);
    assign word    = reg_word_e'(io_addr[3:2]);
    assign acc_ok  = io_sel && aligned && !(io_rd && io_wr);

    always_comb begin
        ev_clr = '0;
        if (acc_ok && word == REG_EVENTS) begin
            if (io_rd) begin
                ev_clr = '1;
            end else if (io_wr) begin
                ev_clr = io_wdata[NUM_BTNS-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            events <= '0;
            irq_en <= '0;
        end else begin
            // New press edges are OR-ed in after the clear, so they survive a coinciding read/W1C.
            events <= (events & ~ev_clr) | rise;
            if (acc_ok && io_wr && word == REG_IRQ_EN) begin
                irq_en <= io_wdata[NUM_BTNS-1:0];
            end
        end
    end

    always_comb begin
        io_rdata = '0;
        if (io_sel && aligned) begin
            unique case (word)
                REG_LEVEL:  io_rdata = 32'(level);
                REG_EVENTS: io_rdata = 32'(events);
                REG_IRQ_EN: io_rdata = 32'(irq_en);
                REG_ID:     io_rdata = ID_VALUE;
                default:    io_rdata = '0;
            endcase
        end
    end

    assign irq = |(events & irq_en);

endmodule
